// File: rtl/uart_ctrl.sv
// uart_ctrl: register-bus controller sequencing a buart core through TX and RX FIFOs
// Ports: clk, reset (sync, active-high); bus_sel/bus_we/bus_addr/bus_wdata in, bus_rdata/bus_rvalid out
// (one-cycle read latency); uart_wr/uart_tx_data out with uart_busy in (launch handshake);
// uart_rd out with uart_rx_data/uart_valid in (receive handshake); irq level interrupt out.
module uart_ctrl #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_busy,
  output logic        uart_rd,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_valid,
  output logic        irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_N = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_N = (RAW+1)'(RX_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, ARM, WAIT} state_t;
  state_t r_state, w_next;
  logic [7:0] r_tx_mem [TX_DEPTH];
  logic [7:0] r_rx_mem [RX_DEPTH];
  logic [TAW-1:0] r_tx_wp, r_tx_rp;
  logic [RAW-1:0] r_rx_wp, r_rx_rp;
  logic [TAW:0] r_tx_cnt;
  logic [RAW:0] r_rx_cnt;
  logic [7:0] r_hold;
  logic [1:0] r_ctrl;
  logic r_ovr, r_drop, r_irq, r_rvalid;
  logic [31:0] r_rdata, w_status, w_rdata;
  logic w_wr, w_rd, w_tx_full, w_tx_idle, w_tx_push, w_tx_pop, w_drop_set;
  logic w_rx_full, w_rx_avail, w_rx_push, w_rx_pop, w_ovr_set, w_ovr_clr, w_drop_clr;
  assign w_wr = bus_sel & bus_we;
  assign w_rd = bus_sel & ~bus_we;
  assign w_tx_full = r_tx_cnt == TX_N;
  assign w_tx_idle = (r_tx_cnt == '0) && (r_state == IDLE);
  assign w_tx_push = w_wr && bus_addr == 2'd0 && !w_tx_full;
  assign w_drop_set = w_wr && bus_addr == 2'd0 && w_tx_full;
  assign w_tx_pop = (r_state == IDLE) && (r_tx_cnt != '0);
  assign w_rx_full = r_rx_cnt == RX_N;
  assign w_rx_avail = r_rx_cnt != '0;
  assign w_rx_pop = w_rd && bus_addr == 2'd0 && w_rx_avail;
  assign uart_rd = uart_valid & ~reset;
  // a bus pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_rx_push = uart_rd && (!w_rx_full || w_rx_pop);
  assign w_ovr_set = uart_rd && w_rx_full && !w_rx_pop;
  assign w_ovr_clr = w_wr && bus_addr == 2'd1 && bus_wdata[3];
  assign w_drop_clr = w_wr && bus_addr == 2'd1 && bus_wdata[4];
  assign uart_wr = (r_state == ISSUE) & ~reset;
  assign uart_tx_data = reset ? 8'd0 : r_hold;
  assign bus_rvalid = r_rvalid & ~reset;
  assign bus_rdata = reset ? 32'd0 : r_rdata;
  assign irq = r_irq & ~reset;
  assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), 3'd0, r_drop, r_ovr, w_rx_avail, w_tx_idle, w_tx_full};
  assign w_rdata = (bus_addr == 2'd0) ? {24'd0, w_rx_avail ? r_rx_mem[r_rx_rp] : 8'd0} :
                   (bus_addr == 2'd1) ? w_status :
                   (bus_addr == 2'd2) ? {30'd0, r_ctrl} : 32'd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_tx_pop ? ISSUE : IDLE;
      ISSUE:   w_next = ARM;
      ARM:     w_next = WAIT;
      default: w_next = uart_busy ? WAIT : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_tx_pop) r_hold <= r_tx_mem[r_tx_rp];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= bus_wdata[7:0];
        r_tx_wp <= r_tx_wp + 1'b1;
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_cnt <= r_tx_cnt + (TAW+1)'(w_tx_push) - (TAW+1)'(w_tx_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= uart_rx_data;
        r_rx_wp <= r_rx_wp + 1'b1;
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt <= r_rx_cnt + (RAW+1)'(w_rx_push) - (RAW+1)'(w_rx_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= 2'd0;
      r_ovr <= 1'b0;
      r_drop <= 1'b0;
      r_irq <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_wr && bus_addr == 2'd2) r_ctrl <= bus_wdata[1:0];
      r_ovr <= w_ovr_set | (r_ovr & ~w_ovr_clr);
      r_drop <= w_drop_set | (r_drop & ~w_drop_clr);
      r_irq <= (r_ctrl[0] & w_rx_avail) | (r_ctrl[1] & w_tx_idle) | r_ovr;
      r_rvalid <= w_rd;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed/randomized bench for uart_ctrl with a queue-based reference model
module tb_uart_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        uart_wr;
  logic [7:0]  uart_tx_data;
  logic        uart_busy = 1'b0;
  logic        uart_rd;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_valid = 1'b0;
  logic        irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] sent[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  bit m_ovr = 1'b0;
  bit m_drop = 1'b0;
  bit force_busy = 1'b0;
  bit busy_fell = 1'b1;
  int busy_left = 0;

  always #5 clk = ~clk;

  uart_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .uart_wr(uart_wr),
    .uart_tx_data(uart_tx_data), .uart_busy(uart_busy), .uart_rd(uart_rd),
    .uart_rx_data(uart_rx_data), .uart_valid(uart_valid), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // UART model: busy for 20 cycles after each launch; a launch must only follow a busy fall
  always @(negedge clk) begin
    if (uart_wr) begin
      sent.push_back(uart_tx_data);
      if (!force_busy) check("wr_after_busy_fell", {31'd0, busy_fell}, 32'd1);
      busy_fell = 1'b0;
      busy_left = 20;
    end
    if (force_busy || busy_left > 0) begin
      uart_busy = 1'b1;
      if (busy_left > 0) busy_left--;
    end else begin
      if (uart_busy) busy_fell = 1'b1;
      uart_busy = 1'b0;
    end
  end

  function automatic logic [31:0] exp_status(input int txc, input bit txidle, input int rxc);
    return {8'd0, 8'(txc), 8'(rxc), 3'd0, m_drop, m_ovr, rxc > 0, txidle, txc == 16};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    bus_sel = 1'b0;
    check("rvalid", {31'd0, bus_rvalid}, 32'd1);
    d = bus_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_valid = 1'b1; uart_rx_data = b;
    #1;
    check("uart_rd_same_cycle", {31'd0, uart_rd}, 32'd1);
    tick();
    uart_valid = 1'b0;
    if (rx_q.size() < 16) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // with the transmitter stuck busy, one byte sits in the hold register, the rest in the FIFO
  task automatic tx_push_held(input logic [7:0] b);
    if (exp_tx.size() == 0 || exp_tx.size() - 1 < 16) exp_tx.push_back(b);
    else m_drop = 1'b1;
    bus_write(2'd0, {24'd0, b});
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, sent.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < sent.size(); i++)
      check(tag, {24'd0, sent[i]}, {24'd0, exp_tx[i]});
    sent.delete();
    exp_tx.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] b;
    int n;
    uart_valid = 1'b1; uart_rx_data = 8'hA5;
    repeat (3) tick();
    check("rst_uart_rd", {31'd0, uart_rd}, 32'd0);
    check("rst_uart_wr", {31'd0, uart_wr}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    uart_valid = 1'b0;
    reset = 1'b0;
    bus_read(2'd1, d);
    check("status_after_reset", d, exp_status(0, 1'b1, 0));
    check("irq_after_reset", {31'd0, irq}, 32'd0);
    check("wr_after_reset", {31'd0, uart_wr}, 32'd0);
    check("rd_after_reset", {31'd0, uart_rd}, 32'd0);

    exp_tx = '{8'h41, 8'h42, 8'h43};
    foreach (exp_tx[i]) bus_write(2'd0, {24'd0, exp_tx[i]});
    repeat (100) tick();
    compare_tx("tx_abc");
    bus_read(2'd1, d);
    check("status_tx_done", d, exp_status(0, 1'b1, 0));

    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      bus_write(2'd0, {24'd0, b});
    end
    repeat (150) tick();
    compare_tx("tx_rand");

    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) tx_push_held(8'($urandom));
    tick();
    bus_read(2'd1, d);
    check("status_16_held", d, exp_status(exp_tx.size() - 1, 1'b0, 0));
    tx_push_held(8'($urandom));
    bus_read(2'd1, d);
    check("status_17_full", d, exp_status(exp_tx.size() - 1, 1'b0, 0));
    tx_push_held(8'($urandom));
    bus_read(2'd1, d);
    check("status_18_drop", d, exp_status(exp_tx.size() - 1, 1'b0, 0));
    bus_write(2'd1, 32'h10);
    m_drop = 1'b0;
    bus_read(2'd1, d);
    check("status_drop_clr", d, exp_status(exp_tx.size() - 1, 1'b0, 0));
    force_busy = 1'b0;
    repeat (500) tick();
    compare_tx("tx_fill");
    bus_read(2'd1, d);
    check("status_fill_done", d, exp_status(0, 1'b1, 0));

    rx_byte(8'($urandom));
    bus_read(2'd1, d);
    check("status_rx_one", d, exp_status(0, 1'b1, rx_q.size()));
    bus_read(2'd0, d);
    check("rx_data_one", d, {24'd0, rx_q.pop_front()});
    bus_read(2'd0, d);
    check("rx_data_empty", d, 32'd0);
    bus_read(2'd1, d);
    check("status_rx_empty", d, exp_status(0, 1'b1, 0));

    for (int i = 0; i < 16; i++) rx_byte(8'($urandom));
    b = 8'($urandom);
    uart_valid = 1'b1; uart_rx_data = b;
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
    tick();
    uart_valid = 1'b0; bus_sel = 1'b0;
    check("rx_pop_push_full", bus_rdata, {24'd0, rx_q.pop_front()});
    rx_q.push_back(b);
    bus_read(2'd1, d);
    check("status_full_no_ovr", d, exp_status(0, 1'b1, rx_q.size()));
    rx_byte(8'($urandom));
    bus_read(2'd1, d);
    check("status_overrun", d, exp_status(0, 1'b1, rx_q.size()));
    check("irq_overrun", {31'd0, irq}, 32'd1);
    while (rx_q.size() > 0) begin
      bus_read(2'd0, d);
      check("rx_drain", d, {24'd0, rx_q.pop_front()});
    end
    bus_read(2'd1, d);
    check("status_drained", d, exp_status(0, 1'b1, 0));
    bus_write(2'd1, 32'h08);
    m_ovr = 1'b0;
    tick();
    check("irq_ovr_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd1, d);
    check("status_ovr_clr", d, exp_status(0, 1'b1, 0));

    bus_write(2'd2, 32'h1);
    rx_byte(8'($urandom));
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    tick();
    check("irq_rx_en", {31'd0, irq}, 32'd1);
    bus_read(2'd2, d);
    check("ctrl_read", d, 32'd1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    check("addr3_read", d, 32'd0);
    bus_read(2'd0, d);
    check("rx_irq_byte", d, {24'd0, rx_q.pop_front()});
    tick();
    check("irq_rx_gone", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h2);
    tick();
    check("irq_tx_en", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h0);
    tick();
    check("irq_ctrl_off", {31'd0, irq}, 32'd0);

    bus_write(2'd2, 32'h1);
    rx_byte(8'($urandom));
    bus_write(2'd0, {24'd0, 8'($urandom)});
    for (int i = 0; i < 10 && sent.size() == 0; i++) tick();
    check("wr_before_reset", sent.size(), 32'd1);
    repeat (3) tick();
    bus_write(2'd0, {24'd0, 8'($urandom)});
    bus_write(2'd0, {24'd0, 8'($urandom)});
    tick();
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    reset = 1'b1; uart_valid = 1'b1;
    tick();
    check("rst2_uart_wr", {31'd0, uart_wr}, 32'd0);
    check("rst2_uart_rd", {31'd0, uart_rd}, 32'd0);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    check("rst2_tx_data", {24'd0, uart_tx_data}, 32'd0);
    uart_valid = 1'b0; reset = 1'b0;
    rx_q.delete(); m_ovr = 1'b0; m_drop = 1'b0; busy_left = 0;
    repeat (60) tick();
    check("no_wr_after_reset", sent.size(), 32'd1);
    check("irq_after_reset2", {31'd0, irq}, 32'd0);
    bus_read(2'd1, d);
    check("status_after_reset2", d, exp_status(0, 1'b1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
